// File: rtl/adder_rr_scheduler_pkg.sv
// Shared constants and types for the round-robin adder scheduler.
package adder_sched_pkg;

    localparam int DEF_ADDER_WIDTH = 33;
    localparam int DEF_NUM_REQ     = 4;

    // Tag width never drops below one bit, so res_id always exists.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_ID_W = id_w(DEF_NUM_REQ);

    typedef struct packed {
        logic [DEF_ADDER_WIDTH:0] sum;
        logic [DEF_ID_W-1:0]      id;
    } res_t;

endpackage

// File: rtl/adder_rr_scheduler_if.sv
// Requester-side and result-side handshake bundle of the adder scheduler.
interface adder_rr_scheduler_if
    import adder_sched_pkg::*;
#(
    parameter int ADDER_WIDTH = DEF_ADDER_WIDTH,
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ID_W        = id_w(NUM_REQ)
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*ADDER_WIDTH-1:0] req_a;
    logic [NUM_REQ*ADDER_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           res_valid;
    logic [ADDER_WIDTH:0]           res_sum;
    logic [ID_W-1:0]                res_id;
    logic                           res_ready;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_sum, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_sum, res_id
    );
endinterface

// File: rtl/adder_tagged_pipe.sv
// Two-stage registered adder (operands, then sum) carrying a valid bit and
// requester tag; both stages move together on a shared advance enable.
module adder_tagged_pipe #(
    parameter int ADDER_WIDTH = 33,
    parameter int ID_W        = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   advance,
    input  logic                   in_valid,
    input  logic [ADDER_WIDTH-1:0] in_a,
    input  logic [ADDER_WIDTH-1:0] in_b,
    input  logic [ID_W-1:0]        in_id,
    output logic                   out_valid,
    output logic [ADDER_WIDTH:0]   out_sum,
    output logic [ID_W-1:0]        out_id
);
    logic                   s1_valid;
    logic [ADDER_WIDTH-1:0] s1_a;
    logic [ADDER_WIDTH-1:0] s1_b;
    logic [ID_W-1:0]        s1_id;

    // Data registers load even on bubbles; consumers qualify with out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_id     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_id    <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_a      <= in_a;
            s1_b      <= in_b;
            s1_id     <= in_id;
            out_valid <= s1_valid;
            out_sum   <= {1'b0, s1_a} + {1'b0, s1_b};
            out_id    <= s1_id;
        end
    end
endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin front end sharing one tagged two-stage adder among NUM_REQ
// requesters; results return on a single backpressured port in grant order.
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter int ADDER_WIDTH = DEF_ADDER_WIDTH,
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ID_W        = id_w(NUM_REQ)
) (
    input logic                 clk,
    input logic                 reset,
    adder_rr_scheduler_if.slave bus
);
    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        grant;
    logic [ID_W-1:0]        ptr_next;
    logic [ID_W:0]          scan;
    logic                   found;
    logic                   advance;
    logic                   transfer;
    logic [ADDER_WIDTH-1:0] sel_a;
    logic [ADDER_WIDTH-1:0] sel_b;

    // Rotate-priority encoder: first valid at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        grant = '0;
        scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(NUM_REQ)) begin
                scan = scan - (ID_W+1)'(NUM_REQ);
            end
            if (!found && bus.req_valid[scan[ID_W-1:0]]) begin
                found = 1'b1;
                grant = scan[ID_W-1:0];
            end
        end
    end

    assign advance  = !(bus.res_valid && !bus.res_ready);
    assign transfer = found && advance && !reset;
    assign ptr_next = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        bus.req_ready = '0;
        if (transfer) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= ptr_next;
        end
    end

    assign sel_a = bus.req_a[int'(grant)*ADDER_WIDTH +: ADDER_WIDTH];
    assign sel_b = bus.req_b[int'(grant)*ADDER_WIDTH +: ADDER_WIDTH];

    adder_tagged_pipe #(
        .ADDER_WIDTH (ADDER_WIDTH),
        .ID_W        (ID_W)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .advance   (advance),
        .in_valid  (transfer),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .in_id     (grant),
        .out_valid (bus.res_valid),
        .out_sum   (bus.res_sum),
        .out_id    (bus.res_id)
    );
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: reference arbiter/pipeline-valid model plus
// an in-order result queue, driven by a vector table and corner sequences.
module tb_adder_rr_scheduler;
    import adder_sched_pkg::*;

    localparam int W    = DEF_ADDER_WIDTH;
    localparam int NREQ = DEF_NUM_REQ;
    localparam int IDW  = DEF_ID_W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    adder_rr_scheduler_if #(.ADDER_WIDTH(W), .NUM_REQ(NREQ), .ID_W(IDW)) bus();

    adder_rr_scheduler #(.ADDER_WIDTH(W), .NUM_REQ(NREQ), .ID_W(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    res_t     q[$];
    int       m_ptr = 0;
    bit       m_rv = 1'b0;
    bit       m_s1v = 1'b0;
    int       m_cnt[NREQ];
    logic [W-1:0] op_a[NREQ];
    logic [W-1:0] op_b[NREQ];
    logic [W:0]     cap_sum;
    logic [IDW-1:0] cap_id;
    logic [NREQ-1:0] prev_v = '0;
    logic [NREQ-1:0] prev_x = '0;
    bit       prev_rst = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluated away from the active edge, then stepped to
    // the state the upcoming posedge will produce.
    logic [NREQ-1:0] exp_rdy;
    bit   g_ok, adv;
    int   g, j;
    res_t r;
    always @(negedge clk) begin
        exp_rdy = '0;
        g_ok = 1'b0;
        g = 0;
        adv = !(m_rv && !bus.res_ready);
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (!g_ok && bus.req_valid[j]) begin
                g_ok = 1'b1;
                g = j;
            end
        end
        if (!(!reset && adv && g_ok)) g_ok = 1'b0;
        if (g_ok) exp_rdy[g] = 1'b1;

        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        chk("res_valid", 64'(bus.res_valid), 64'(m_rv));
        if (m_rv) begin
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard: result expected but queue empty at %0t", $time);
            end else begin
                chk("res_sum", 64'(bus.res_sum), 64'(q[0].sum));
                chk("res_id", 64'(bus.res_id), 64'(q[0].id));
                if (bus.res_ready) void'(q.pop_front());
            end
        end
        if (bus.res_valid && bus.res_ready) begin
            cap_sum = bus.res_sum;
            cap_id  = bus.res_id;
        end

        for (int i = 0; i < NREQ; i++) begin
            if (prev_v[i] && !prev_x[i] && !prev_rst && !bus.req_valid[i]) begin
                n_bad++;
                $display("FAIL protocol: requester %0d dropped valid without transfer at %0t", i, $time);
            end
        end
        prev_v   = bus.req_valid;
        prev_x   = exp_rdy;
        prev_rst = reset;

        if (reset) begin
            m_rv = 1'b0;
            m_s1v = 1'b0;
            m_ptr = 0;
            q.delete();
        end else if (adv) begin
            m_rv = m_s1v;
            m_s1v = g_ok;
            if (g_ok) begin
                r.sum = {1'b0, op_a[g]} + {1'b0, op_b[g]};
                r.id  = IDW'(g);
                q.push_back(r);
                m_ptr = (g + 1) % NREQ;
                m_cnt[g]++;
            end
        end
    end

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = op_a[i];
            bus.req_b[i*W +: W] = op_b[i];
        end
    endtask

    // Each requester in mask issues n transfers, holding valid until granted;
    // optional stall drops res_ready for stall_len cycles at the first result.
    task automatic run_streams(input logic [NREQ-1:0] mask, input int n,
                               input int stall_len, input int budget);
        int  start[NREQ];
        int  left = 0;
        int  cyc = 0;
        bit  stalled = 1'b0;
        for (int i = 0; i < NREQ; i++) start[i] = m_cnt[i];
        pack_ops();
        bus.req_valid = mask;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && (m_cnt[i] - start[i] >= n)) bus.req_valid[i] = 1'b0;
            end
            if (stall_len > 0 && !stalled && m_rv) begin
                bus.res_ready = 1'b0;
                left = stall_len;
                stalled = 1'b1;
            end else if (left > 0) begin
                left--;
                if (left == 0) bus.res_ready = 1'b1;
            end
            if (bus.req_valid == '0 && q.size() == 0 && !m_rv && !m_s1v && bus.res_ready) break;
            if (cyc >= budget) begin
                n_bad++;
                $display("FAIL timeout: streams mask=%b not drained after %0d cycles", mask, cyc);
                bus.req_valid = '0;
                bus.res_ready = 1'b1;
                break;
            end
        end
    endtask

    task automatic reset_dut(input int cycles);
        reset = 1'b1;
        bus.req_valid = '1;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        bus.req_valid = '0;
    endtask

    typedef struct {
        int         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   sum;
    } vec_t;

    vec_t vecs[5];
    logic [W-1:0] maxv;
    logic [NREQ-1:0] m;

    initial begin
        maxv = '1;
        vecs[0] = '{0, 33'd5, 33'd7, 34'd12};
        vecs[1] = '{1, maxv, maxv, 34'h3_FFFF_FFFE};
        vecs[2] = '{2, maxv, 33'd1, 34'h2_0000_0000};
        vecs[3] = '{3, 33'd0, 33'd0, 34'd0};
        vecs[4] = '{1, 33'd123456, 33'd654321, 34'd777777};

        for (int i = 0; i < NREQ; i++) begin
            m_cnt[i] = 0;
            op_a[i] = '0;
            op_b[i] = '0;
        end
        pack_ops();
        bus.res_ready = 1'b1;
        reset_dut(3);
        chk("reset_res_valid", 64'(bus.res_valid), 64'd0);
        chk("reset_res_sum", 64'(bus.res_sum), 64'd0);
        chk("reset_res_id", 64'(bus.res_id), 64'd0);

        // Single-requester vectors, including carry-out extremes.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < NREQ; i++) begin
                op_a[i] = '0;
                op_b[i] = '0;
            end
            op_a[vecs[v].id] = vecs[v].a;
            op_b[vecs[v].id] = vecs[v].b;
            m = '0;
            m[vecs[v].id] = 1'b1;
            cap_sum = '1;
            cap_id  = '1;
            run_streams(m, 1, 0, 50);
            chk("vec_sum", 64'(cap_sum), 64'(vecs[v].sum));
            chk("vec_id", 64'(cap_id), 64'(vecs[v].id));
        end

        // Fairness: all four valid, two rounds of grants.
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = W'(i);
            op_b[i] = W'(100);
        end
        run_streams('1, 2, 0, 100);

        // Backpressure: four back-to-back grants, 3-cycle stall at first result.
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = W'(1000 + i);
            op_b[i] = W'(i * 3);
        end
        run_streams('1, 1, 3, 100);

        // Requester 2 alone for 5 grants, then everyone: rotation resumes at 3.
        op_a[2] = W'(42);
        op_b[2] = W'(58);
        run_streams(4'b0100, 5, 0, 100);
        run_streams('1, 1, 0, 100);

        // Reset mid-flight: two transfers, result parked, reset discards both.
        reset_dut(2);
        op_a[0] = W'(10); op_b[0] = W'(1);
        op_a[1] = W'(20); op_b[1] = W'(2);
        pack_ops();
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b0011;
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("post_reset_res_valid", 64'(bus.res_valid), 64'd0);
            @(posedge clk); #1;
        end
        op_a[3] = W'(7);
        op_b[3] = W'(8);
        cap_sum = '1;
        cap_id  = '0;
        run_streams(4'b1000, 1, 0, 50);
        chk("post_reset_sum", 64'(cap_sum), 64'd15);
        chk("post_reset_id", 64'(cap_id), 64'd3);
        run_streams('1, 1, 0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
